// File: rtl/vedic_mult_pipe.sv
// Pipelined divide-and-conquer multiplier with valid/ready handshake.
// The operands are reduced to magnitudes in S1, and four half-width partial
// products are formed in S2 by recursive splitting down to LEAF_WIDTH.
// S3 recombines the partial products and restores the sign.
// A single global advance signal stalls every stage together when the
// output is held by the consumer.

module vedic_mult_rec #(
  parameter int W    = 16,
  parameter int LEAF = 8
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  generate
    if (W <= LEAF) begin : g_leaf
      assign p_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    end else begin : g_split
      localparam int H = W / 2;
      logic [W-1:0] p_ll, p_lh, p_hl, p_hh;
      logic [W:0]   mid;

      vedic_mult_rec #(.W(H), .LEAF(LEAF)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(p_ll));
      vedic_mult_rec #(.W(H), .LEAF(LEAF)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[W-1:H]), .p_o(p_lh));
      vedic_mult_rec #(.W(H), .LEAF(LEAF)) u_hl (.a_i(a_i[W-1:H]), .b_i(b_i[H-1:0]), .p_o(p_hl));
      vedic_mult_rec #(.W(H), .LEAF(LEAF)) u_hh (.a_i(a_i[W-1:H]), .b_i(b_i[W-1:H]), .p_o(p_hh));

      // pHH and pLL never overlap, so they concatenate; the cross terms add in at H.
      assign mid = {1'b0, p_lh} + {1'b0, p_hl};
      assign p_o = {p_hh, p_ll} + ({{(W-1){1'b0}}, mid} << H);
    end
  endgenerate
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH      = 32,
  parameter int LEAF_WIDTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int HW = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  // Magnitude of a possibly-negative operand; -2^(WIDTH-1) maps to 2^(WIDTH-1), still fits.
  function automatic logic [WIDTH-1:0] op_mag(input logic [WIDTH-1:0] x, input logic sgn);
    op_mag = (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // Two's-complement negate of the full-width magnitude when the result is negative.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] m, input logic neg);
    apply_sign = neg ? (~m + PW'(1)) : m;
  endfunction

  logic adv, acc;

  logic             vld_p1_q, vld_p2_q, vld_p3_q;
  logic [WIDTH-1:0] mag_a_p1_d, mag_b_p1_d, mag_a_p1_q, mag_b_p1_q;
  logic             neg_p1_d, neg_p1_q, neg_p2_q;
  logic [TAG_W-1:0] tag_p1_q, tag_p2_q, tag_p3_q;

  logic [WIDTH-1:0] pll_p2_d, plh_p2_d, phl_p2_d, phh_p2_d;
  logic [WIDTH-1:0] pll_p2_q, plh_p2_q, phl_p2_q, phh_p2_q;

  logic [WIDTH:0]   mid_p2;
  logic [PW-1:0]    mag_p2;
  logic [PW-1:0]    prod_p3_d, prod_p3_q;

  // Stall everything only when a result is waiting and the consumer refuses it.
  assign adv      = !vld_p3_q || out_ready;
  assign in_ready = adv && !rst;
  assign acc      = in_valid && in_ready;

  assign out_valid = vld_p3_q;
  assign out_prod  = prod_p3_q;
  assign out_tag   = tag_p3_q;

  // ---- S1: capture magnitudes and result sign ----
  assign mag_a_p1_d = op_mag(in_a, in_signed);
  assign mag_b_p1_d = op_mag(in_b, in_signed);
  assign neg_p1_d   = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  // Valid flags shift together on advance; reset empties the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= acc;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // S1 operand registers load only on an accepted transaction.
  always_ff @(posedge clk) begin
    if (acc) begin
      mag_a_p1_q <= mag_a_p1_d;
      mag_b_p1_q <= mag_b_p1_d;
      neg_p1_q   <= neg_p1_d;
      tag_p1_q   <= in_tag;
    end
  end

  // ---- S2: four half-width partial products ----
  vedic_mult_rec #(.W(HW), .LEAF(LEAF_WIDTH)) u_pll (.a_i(mag_a_p1_q[HW-1:0]),     .b_i(mag_b_p1_q[HW-1:0]),     .p_o(pll_p2_d));
  vedic_mult_rec #(.W(HW), .LEAF(LEAF_WIDTH)) u_plh (.a_i(mag_a_p1_q[HW-1:0]),     .b_i(mag_b_p1_q[WIDTH-1:HW]), .p_o(plh_p2_d));
  vedic_mult_rec #(.W(HW), .LEAF(LEAF_WIDTH)) u_phl (.a_i(mag_a_p1_q[WIDTH-1:HW]), .b_i(mag_b_p1_q[HW-1:0]),     .p_o(phl_p2_d));
  vedic_mult_rec #(.W(HW), .LEAF(LEAF_WIDTH)) u_phh (.a_i(mag_a_p1_q[WIDTH-1:HW]), .b_i(mag_b_p1_q[WIDTH-1:HW]), .p_o(phh_p2_d));

  // S2 partial-product registers load when a valid S1 entry moves forward.
  always_ff @(posedge clk) begin
    if (adv && vld_p1_q) begin
      pll_p2_q <= pll_p2_d;
      plh_p2_q <= plh_p2_d;
      phl_p2_q <= phl_p2_d;
      phh_p2_q <= phh_p2_d;
      neg_p2_q <= neg_p1_q;
      tag_p2_q <= tag_p1_q;
    end
  end

  // ---- S3: recombine and restore sign ----
  assign mid_p2    = {1'b0, plh_p2_q} + {1'b0, phl_p2_q};
  assign mag_p2    = {phh_p2_q, pll_p2_q} + ({{(WIDTH-1){1'b0}}, mid_p2} << HW);
  assign prod_p3_d = apply_sign(mag_p2, neg_p2_q);

  // Output registers clear on reset and otherwise hold until a new result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_p3_q <= '0;
      tag_p3_q  <= '0;
    end else if (adv && vld_p2_q) begin
      prod_p3_q <= prod_p3_d;
      tag_p3_q  <= tag_p2_q;
    end
  end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe: queue-based reference model checked on every
// negative edge, plus directed vectors with literal expected products.

module tb_vedic_mult_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;
  logic [3:0]  out_tag;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  logic [67:0] q[$];
  logic        hold;
  logic [63:0] hold_prod;
  logic [3:0]  hold_tag;

  logic [31:0] da[8], db[8];
  logic        ds[8];
  logic [3:0]  dt[8];

  vedic_mult_pipe #(.WIDTH(32), .LEAF_WIDTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain arithmetic on sign- or zero-extended operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ref_prod = sa * sb;
    end else begin
      ref_prod = {32'b0, a} * {32'b0, b};
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare process: tracks accepted ops in order and checks every output transfer.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold = 1'b0;
      chk("in_ready_in_reset", {63'b0, in_ready}, 64'd0);
    end else begin
      if (hold) begin
        chk("hold_valid", {63'b0, out_valid}, 64'd1);
        chk("hold_prod", out_prod, hold_prod);
        chk("hold_tag", {60'b0, out_tag}, {60'b0, hold_tag});
      end
      chk("in_ready", {63'b0, in_ready}, {63'b0, (!out_valid || out_ready)});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_output", {60'b0, out_tag}, 64'hDEAD);
        end else begin
          logic [67:0] e;
          e = q.pop_front();
          chk("stream_prod", out_prod, e[67:4]);
          chk("stream_tag", {60'b0, out_tag}, {60'b0, e[3:0]});
          n_out++;
        end
      end
      if (in_valid && in_ready)
        q.push_back({ref_prod(in_a, in_b, in_signed), in_tag});
      hold      = out_valid && !out_ready;
      hold_prod = out_prod;
      hold_tag  = out_tag;
    end
  end

  // Single op with literal expectation and exact 3-cycle latency; pipeline must be empty.
  task automatic do_one(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [3:0] t, input logic [63:0] exp, input string nm);
    chk({nm, "_model"}, ref_prod(a, b, s), exp);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
    @(negedge clk);
    chk({nm, "_in_ready"}, {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_lat1"}, {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk({nm, "_lat2"}, {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk({nm, "_prod"}, out_prod, exp);
    chk({nm, "_tag"}, {60'b0, out_tag}, {60'b0, t});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 9))
      0: rnd_op = 32'h0000_0000;
      1: rnd_op = 32'hFFFF_FFFF;
      2: rnd_op = 32'h8000_0000;
      3: rnd_op = 32'h7FFF_FFFF;
      default: rnd_op = $urandom;
    endcase
  endfunction

  // Streams n ops (table or random), with out_ready either random or low for cycles bp_lo..bp_hi.
  task automatic run_stream(input int n, input bit rnd, input int bp_lo, input int bp_hi, input bit drain);
    int idx = 0;
    int cyc = 0;
    int guard = 0;
    bit have = 0;
    while (idx < n) begin
      @(posedge clk); #1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= bp_lo && cyc <= bp_hi);
      if (!have && (!rnd || $urandom_range(0, 4) != 0)) begin
        if (rnd) begin
          in_a = rnd_op(); in_b = rnd_op();
          in_signed = $urandom_range(0, 1) == 1;
          in_tag = 4'($urandom_range(0, 15));
        end else begin
          in_a = da[idx]; in_b = db[idx]; in_signed = ds[idx]; in_tag = dt[idx];
        end
        have = 1;
      end
      in_valid = have;
      @(negedge clk);
      if (in_valid && in_ready) begin
        idx++;
        have = 0;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= bp_lo && cyc <= bp_hi);
    cyc++;
    if (drain) begin
      @(negedge clk);
      while (q.size() > 0 && guard < 200) begin
        @(posedge clk); #1;
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= bp_lo && cyc <= bp_hi);
        @(negedge clk);
        cyc++;
        guard++;
      end
      chk("drain_left", 64'(q.size()), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_out_prod", out_prod, 64'd0);
    chk("reset_out_tag", {60'b0, out_tag}, 64'd0);
    rst = 1'b0;

    do_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd5, 64'hFFFF_FFFE_0000_0001, "uns_max");
    do_one(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd1, 64'h4000_0000_0000_0000, "sgn_min");
    do_one(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFEB, "sgn_m3x7");
    do_one(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 4'd3, 64'h0, "sgn_zero");
    do_one(32'h0001_0000, 32'h0001_0000, 1'b0, 4'd9, 64'h0000_0001_0000_0000, "uns_cross");

    // Mixed mode back to back: signed then unsigned on the same operands.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_signed = 1'b1; in_tag = 4'd7;
    @(posedge clk); #1;
    in_signed = 1'b0; in_tag = 4'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mixed1_valid", {63'b0, out_valid}, 64'd1);
    chk("mixed1_prod", out_prod, 64'h1);
    chk("mixed1_tag", {60'b0, out_tag}, 64'd7);
    @(posedge clk); #1;
    chk("mixed2_valid", {63'b0, out_valid}, 64'd1);
    chk("mixed2_prod", out_prod, 64'hFFFF_FFFE_0000_0001);
    chk("mixed2_tag", {60'b0, out_tag}, 64'd8);
    @(posedge clk); #1;
    chk("mixed_end_valid", {63'b0, out_valid}, 64'd0);

    // Backpressure: 8 ops with out_ready low for stream cycles 4..9.
    for (int i = 0; i < 8; i++) begin
      da[i] = 32'h1234_5678 * (i + 1) + 32'(i);
      db[i] = (i % 2 == 0) ? 32'hF000_0001 - 32'(i) : 32'h0000_0100 + 32'(i);
      ds[i] = (i % 3 == 0);
      dt[i] = 4'(i + 2);
    end
    base = n_out;
    run_stream(8, 1'b0, 4, 9, 1'b1);
    chk("bp_count", 64'(n_out - base), 64'd8);

    // Reset mid-stream: in-flight ops are discarded and nothing stale appears.
    run_stream(4, 1'b0, 100, 100, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_prod", out_prod, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("midrst_valid2", {63'b0, out_valid}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("postrst_no_stale", {63'b0, out_valid}, 64'd0);
    end

    // Random traffic with random consumer stalls.
    base = n_out;
    run_stream(10000, 1'b1, 0, 0, 1'b1);
    chk("rand_count", 64'(n_out - base), 64'd10000);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
